afifo_wr_ctrl: RTL

Write-domain controller for the pipelined CPU's asynchronous FIFO. It owns the binary/Gray write pointer and drives the dual-port memory write port. It computes full/almost-full and a fill level from the read pointer, which arrives already passed through the write-domain two-flop synchronizer. It also sequences a flush-drain handshake so upstream logic can wait until the read side has consumed everything written.

---
 rtl/afifo_pkg.sv | 18 +
 rtl/afifo_gray_ptr.sv | 32 +++
 rtl/afifo_wr_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// afifo_pkg: pointer code conversions, full compare and flush FSM encoding shared by both FIFO controllers
// bin2gray/gray2bin/full_match work on zero-extended MAX_W vectors so any pointer width up to MAX_W fits
package afifo_pkg;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE, DRAIN, ACK, WAIT} flush_state_t;
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    for (int i = 0; i < MAX_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  // Full when the write Gray pointer equals the read one with its top two bits inverted
  function automatic logic full_match(input logic [MAX_W-1:0] wg, input logic [MAX_W-1:0] rg, input int w);
    return wg == (rg ^ (MAX_W'(3) << (w - 2)));
  endfunction
endpackage

// File: rtl/afifo_gray_ptr.sv
// afifo_gray_ptr: binary+Gray FIFO pointer register with increment enable
// clk/reset: clock, sync active-high reset; i_inc: advance pointer
// o_addr: memory address (binary without wrap bit); o_bin_next/o_gray_next: next-state pointer; o_gray: registered Gray pointer
module afifo_gray_ptr
  import afifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-2:0] o_addr,
  output logic [W-1:0] o_bin_next,
  output logic [W-1:0] o_gray,
  output logic [W-1:0] o_gray_next
);
  logic [W-1:0] r_bin;
  logic [W-1:0] r_gray;
  assign o_bin_next  = r_bin + W'(i_inc);
  assign o_gray_next = W'(bin2gray(MAX_W'(o_bin_next)));
  assign o_addr      = r_bin[W-2:0];
  assign o_gray      = r_gray;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= o_bin_next;
      r_gray <= o_gray_next;
    end
  end
endmodule

// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: async FIFO write-domain controller with full/almost-full/level flags and flush-drain handshake
// wr_valid/wr_data/wr_ready: producer handshake; rptr_gray_sync: synchronized read Gray pointer; wptr_gray: to read domain
// mem_we/mem_waddr/mem_wdata: memory write port; full/almost_full/level: registered pessimistic status; flush_req/flush_ack: drain handshake
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  input  logic                  flush_req,
  output logic                  flush_ack
);
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  flush_state_t     r_state;
  logic             r_full;
  logic             r_afull;
  logic             r_ack;
  logic [PTR_W-1:0] r_level;
  logic             w_accept;
  logic             w_drained;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rbin;
  logic [PTR_W-1:0] w_level_next;
  assign wr_ready     = ~r_full & (r_state == IDLE) & ~reset;
  assign w_accept     = wr_valid & wr_ready;
  assign mem_we       = w_accept;
  assign mem_wdata    = wr_data;
  assign w_rbin       = PTR_W'(gray2bin(MAX_W'(rptr_gray_sync)));
  assign w_level_next = w_wbin_next - w_rbin;
  assign w_drained    = rptr_gray_sync == wptr_gray;
  assign full         = r_full;
  assign almost_full  = r_afull;
  assign level        = r_level;
  assign flush_ack    = r_ack;
  afifo_gray_ptr #(.W(PTR_W)) u_wptr (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_accept),
    .o_addr      (mem_waddr),
    .o_bin_next  (w_wbin_next),
    .o_gray      (wptr_gray),
    .o_gray_next (w_wgray_next)
  );
  // ACK and WAIT share one exit rule: hold off new writes until flush_req drops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_full  <= full_match(MAX_W'(w_wgray_next), MAX_W'(rptr_gray_sync), PTR_W);
      r_level <= w_level_next;
      r_afull <= w_level_next >= PTR_W'(DEPTH - AFULL_THRESH);
      r_ack   <= (r_state == DRAIN) & w_drained;
      r_state <= (r_state == IDLE)  ? (flush_req ? DRAIN : IDLE) :
                 (r_state == DRAIN) ? (w_drained ? ACK : DRAIN) :
                 (flush_req ? WAIT : IDLE);
    end
  end
endmodule
